conv_rr_scheduler: RTL



---
 rtl/conv_rr_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_rr_scheduler.sv
`default_nettype none
// ============================================================================
// conv_rr_scheduler: three soc/eoc converter front-ends, each with a
// one-sample buffer, merged round-robin onto a shared dav_/rfd channel.
// Rev 1.0
// ============================================================================
module conv_rr_scheduler #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic         eoc1,
    input  logic         eoc2,
    input  logic         eoc3,
    output logic         soc1,
    output logic         soc2,
    output logic         soc3,
    output logic [W-1:0] out,
    output logic [1:0]   chan,
    output logic         dav_,
    input  logic         rfd
);

    typedef enum logic [1:0] {
        C_START = 2'd0,
        C_WAIT  = 2'd1,
        C_HOLD  = 2'd2
    } chan_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_ACK  = 2'd1,
        O_REL  = 2'd2
    } out_state_t;

    logic [W-1:0] w_x   [3];
    logic [W-1:0] r_buf [3];
    logic [2:0]   w_eoc;
    logic [2:0]   r_soc;
    logic [2:0]   r_full;
    logic [2:0]   w_clr;

    assign w_x[0] = x1;
    assign w_x[1] = x2;
    assign w_x[2] = x3;
    assign w_eoc  = {eoc3, eoc2, eoc1};
    assign soc1   = r_soc[0];
    assign soc2   = r_soc[1];
    assign soc3   = r_soc[2];

    for (genvar i = 0; i < 3; i++) begin : g_chan
        chan_state_t  r_state;
        chan_state_t  w_state_nxt;
        logic         r_soc_q;
        logic         r_full_q;
        logic [W-1:0] r_buf_q;

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                C_START: if (!w_eoc[i]) w_state_nxt = C_WAIT;
                C_WAIT:  if (w_eoc[i])  w_state_nxt = C_HOLD;
                C_HOLD:  if (!r_full_q) w_state_nxt = C_START;
                default: w_state_nxt = C_START;
            endcase
        end

        // A grant only ever clears a channel sitting in C_HOLD, so it never meets a capture.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state  <= C_START;
                r_soc_q  <= 1'b0;
                r_full_q <= 1'b0;
                r_buf_q  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_soc_q <= (r_state == C_START) && w_eoc[i];
                if ((r_state == C_WAIT) && w_eoc[i]) begin
                    r_buf_q  <= w_x[i];
                    r_full_q <= 1'b1;
                end else if (w_clr[i]) begin
                    r_full_q <= 1'b0;
                end
            end
        end

        assign r_soc[i]  = r_soc_q;
        assign r_full[i] = r_full_q;
        assign r_buf[i]  = r_buf_q;
    end

    out_state_t r_ostate;
    out_state_t w_ostate_nxt;
    logic [1:0] r_rr_last;
    logic       w_gnt_vld;
    logic [1:0] w_gnt;
    logic [1:0] w_idx;

    // Scan from the channel after the last grant; the lowest offset that is full wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        w_idx     = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            w_idx = 2'((int'(r_rr_last) + k) % 3);
            if (r_full[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx + 2'd1;
            end
        end
    end

    assign w_clr = ((r_ostate == O_IDLE) && w_gnt_vld) ? (3'b001 << (w_gnt - 2'd1)) : 3'b000;

    always_comb begin
        w_ostate_nxt = r_ostate;
        case (r_ostate)
            O_IDLE:  if (w_gnt_vld) w_ostate_nxt = O_ACK;
            O_ACK:   if (!rfd)      w_ostate_nxt = O_REL;
            O_REL:   if (rfd)       w_ostate_nxt = O_IDLE;
            default: w_ostate_nxt = O_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ostate  <= O_IDLE;
            r_rr_last <= 2'd3;
            out       <= '0;
            chan      <= 2'd0;
            dav_      <= 1'b1;
        end else begin
            r_ostate <= w_ostate_nxt;
            if (w_clr != 3'b000) begin
                out       <= r_buf[w_gnt - 2'd1];
                chan      <= w_gnt;
                r_rr_last <= w_gnt;
                dav_      <= 1'b0;
            end else if ((r_ostate == O_ACK) && !rfd) begin
                dav_ <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
